// File: rtl/hamming_secded_decoder.sv
// Two-stage pipelined SECDED Hamming decoder with a valid/ready stream interface
// and saturating counters for corrected and uncorrectable words.
module hamming_secded_decoder #(
  parameter int DATA_W     = 4,
  parameter bit ODD_PARITY = 1'b1,
  parameter int CNT_W      = 16,
  localparam int P         = (DATA_W <= 4) ? 3 : (DATA_W <= 11) ? 4 : (DATA_W <= 26) ? 5 : 6,
  localparam int CODE_W    = DATA_W + P + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err_single,
  output logic              out_err_double,
  output logic [P-1:0]      out_syndrome,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  function automatic logic [P-1:0] calc_syndrome(input logic [CODE_W-1:0] code);
    logic [P-1:0] syn;
    syn = {P{ODD_PARITY}};
    for (int i = 1; i < CODE_W; i++) begin
      for (int j = 0; j < P; j++) begin
        syn[j] = syn[j] ^ (code[i] & i[j]);
      end
    end
    return syn;
  endfunction

  function automatic logic calc_overall(input logic [CODE_W-1:0] code);
    return (^code) ^ ODD_PARITY;
  endfunction

  // Data bits occupy the non-power-of-two positions in ascending order.
  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
    logic [DATA_W-1:0] data;
    int                k;
    data = '0;
    k    = 0;
    for (int i = 1; i < CODE_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        data[k] = code[i];
        k       = k + 1;
      end
    end
    return data;
  endfunction

  logic              s1_valid_q, s1_valid_d;
  logic [CODE_W-1:0] s1_code_q, s1_code_d;
  logic [P-1:0]      s1_syn_q, s1_syn_d;
  logic              s1_ov_q, s1_ov_d;

  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s2_data_q, s2_data_d;
  logic              s2_single_q, s2_single_d;
  logic              s2_double_q, s2_double_d;
  logic [P-1:0]      s2_syn_q, s2_syn_d;

  logic [CNT_W-1:0]  corr_q, corr_d;
  logic [CNT_W-1:0]  uncorr_q, uncorr_d;

  logic              s2_load_s, s1_adv_s, s1_load_s, fire_s;
  logic [CODE_W-1:0] mask_s, corrected_s;
  logic              in_range_s, single_s, double_s;

  assign s2_load_s = !s2_valid_q || out_ready;
  assign s1_adv_s  = s1_valid_q && s2_load_s;
  assign s1_load_s = !s1_valid_q || s1_adv_s;
  assign in_ready  = rst_n && s1_load_s;
  assign fire_s    = s2_valid_q && out_ready;

  // Classify the S1 word and build the corrected codeword.
  always_comb begin
    mask_s   = '0;
    single_s = 1'b0;
    double_s = 1'b0;
    for (int i = 1; i < CODE_W; i++) begin
      mask_s[i] = (s1_syn_q == P'(i));
    end
    in_range_s = |mask_s;
    if (s1_ov_q) begin
      if (s1_syn_q == '0) begin
        single_s = 1'b1;
      end else if (in_range_s) begin
        single_s = 1'b1;
      end else begin
        double_s = 1'b1;
      end
    end else begin
      if (s1_syn_q != '0) begin
        double_s = 1'b1;
      end else begin
        single_s = 1'b0;
      end
    end
    if (s1_ov_q && in_range_s) begin
      corrected_s = s1_code_q ^ mask_s;
    end else begin
      corrected_s = s1_code_q;
    end
  end

  // Stage 1: capture the codeword with its syndrome and overall parity.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_code_d  = s1_code_q;
    s1_syn_d   = s1_syn_q;
    s1_ov_d    = s1_ov_q;
    if (s1_load_s) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_code_d = in_code;
        s1_syn_d  = calc_syndrome(in_code);
        s1_ov_d   = calc_overall(in_code);
      end else begin
        s1_code_d = s1_code_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Stage 2: output register; holds while downstream stalls.
  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_data_d   = s2_data_q;
    s2_single_d = s2_single_q;
    s2_double_d = s2_double_q;
    s2_syn_d    = s2_syn_q;
    if (s2_load_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d   = extract_data(corrected_s);
        s2_single_d = single_s;
        s2_double_d = double_s;
        s2_syn_d    = s1_syn_q;
      end else begin
        s2_data_d = s2_data_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Event counters: clear wins over a same-cycle increment.
  always_comb begin
    corr_d   = corr_q;
    uncorr_d = uncorr_q;
    if (cnt_clr) begin
      corr_d   = '0;
      uncorr_d = '0;
    end else if (fire_s) begin
      if (s2_single_q && (corr_q != {CNT_W{1'b1}})) begin
        corr_d = corr_q + CNT_W'(1);
      end else begin
        corr_d = corr_q;
      end
      if (s2_double_q && (uncorr_q != {CNT_W{1'b1}})) begin
        uncorr_d = uncorr_q + CNT_W'(1);
      end else begin
        uncorr_d = uncorr_q;
      end
    end else begin
      corr_d = corr_q;
    end
  end

  // State registers for both stages and the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_code_q   <= '0;
      s1_syn_q    <= '0;
      s1_ov_q     <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_single_q <= 1'b0;
      s2_double_q <= 1'b0;
      s2_syn_q    <= '0;
      corr_q      <= '0;
      uncorr_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_code_q   <= s1_code_d;
      s1_syn_q    <= s1_syn_d;
      s1_ov_q     <= s1_ov_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      s2_single_q <= s2_single_d;
      s2_double_q <= s2_double_d;
      s2_syn_q    <= s2_syn_d;
      corr_q      <= corr_d;
      uncorr_q    <= uncorr_d;
    end
  end

  assign out_valid      = s2_valid_q;
  assign out_data       = s2_data_q;
  assign out_err_single = s2_single_q;
  assign out_err_double = s2_double_q;
  assign out_syndrome   = s2_syn_q;
  assign corr_cnt       = corr_q;
  assign uncorr_cnt     = uncorr_q;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Directed scoreboard bench for hamming_secded_decoder (DATA_W=4, odd parity);
// a second instance with CNT_W=2 shares the stimulus to exercise saturation.
module tb_hamming_secded_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready, u2_in_ready;
  logic [7:0] in_code;
  logic       out_valid, u2_out_valid;
  logic       out_ready;
  logic [3:0] out_data, u2_out_data;
  logic       out_err_single, u2_out_err_single;
  logic       out_err_double, u2_out_err_double;
  logic [2:0] out_syndrome, u2_out_syndrome;
  logic       cnt_clr;
  logic [15:0] corr_cnt, uncorr_cnt;
  logic [1:0]  u2_corr_cnt, u2_uncorr_cnt;

  always #5 clk = ~clk;

  hamming_secded_decoder u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err_single(out_err_single), .out_err_double(out_err_double),
    .out_syndrome(out_syndrome), .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  hamming_secded_decoder #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u2_in_ready), .in_code(in_code),
    .out_valid(u2_out_valid), .out_ready(out_ready), .out_data(u2_out_data),
    .out_err_single(u2_out_err_single), .out_err_double(u2_out_err_double),
    .out_syndrome(u2_out_syndrome), .cnt_clr(cnt_clr), .corr_cnt(u2_corr_cnt),
    .uncorr_cnt(u2_uncorr_cnt)
  );

  typedef struct {
    logic [3:0] d;
    logic       sgl;
    logic       dbl;
    logic [2:0] syn;
    int         acc;
    bit         lat;
  } exp_t;

  exp_t        q[$];
  exp_t        pend;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          tog = 1'b0;
  bit          chk_lat = 1'b0;
  bit          accepted = 1'b0;
  bit          saw_stall = 1'b0;
  bit          hold_prev = 1'b0;
  logic [8:0]  prev_out;
  logic [15:0] m_corr, m_uncorr;
  logic [1:0]  m2_corr, m2_uncorr;

  // Reference encoder: odd-parity SECDED, data in non-power-of-two positions.
  function automatic logic [7:0] enc(input logic [3:0] d);
    logic [7:0] c;
    logic       x;
    int         k;
    c = 8'h00;
    k = 0;
    for (int i = 1; i < 8; i++) begin
      if ((i & (i - 1)) != 0) begin
        c[i] = d[k];
        k++;
      end
    end
    for (int j = 0; j < 3; j++) begin
      x = 1'b1;
      for (int i = 1; i < 8; i++) begin
        if (i != (1 << j) && ((i >> j) & 1) == 1) x = x ^ c[i];
      end
      c[1 << j] = x;
    end
    c[0] = 1'b1 ^ (^c[7:1]);
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Per-cycle scoreboard/monitor step, run on the falling edge.
  task automatic mon();
    exp_t e;
    logic sgl, dbl, fire;
    sgl  = 1'b0;
    dbl  = 1'b0;
    fire = 1'b0;
    if (!rst_n) begin
      q.delete();
      m_corr = '0; m_uncorr = '0; m2_corr = '0; m2_uncorr = '0;
      hold_prev = 1'b0;
    end else begin
      if (!in_ready) saw_stall = 1'b1;
      check("in_ready", in_ready, !(q.size() == 2 && !out_ready));
      if (hold_prev)
        check("hold_stable", {out_valid, out_data, out_err_single, out_err_double, out_syndrome},
              {1'b1, prev_out});
      hold_prev = out_valid && !out_ready;
      prev_out  = {out_data, out_err_single, out_err_double, out_syndrome};
      check("corr_cnt", corr_cnt, m_corr);
      check("uncorr_cnt", uncorr_cnt, m_uncorr);
      check("sat_corr_cnt", u2_corr_cnt, m2_corr);
      check("sat_uncorr_cnt", u2_uncorr_cnt, m2_uncorr);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          e = q.pop_front();
          fire = 1'b1;
          check("out_data", out_data, e.d);
          check("err_single", out_err_single, e.sgl);
          check("err_double", out_err_double, e.dbl);
          check("syndrome", out_syndrome, e.syn);
          if (e.lat) check("latency", cyc - e.acc, 2);
          sgl = e.sgl;
          dbl = e.dbl;
        end
      end
      if (cnt_clr) begin
        m_corr = '0; m_uncorr = '0; m2_corr = '0; m2_uncorr = '0;
      end else if (fire) begin
        if (sgl && m_corr != 16'hFFFF) m_corr++;
        if (dbl && m_uncorr != 16'hFFFF) m_uncorr++;
        if (sgl && m2_corr != 2'd3) m2_corr++;
        if (dbl && m2_uncorr != 2'd3) m2_uncorr++;
      end
      if (in_valid && in_ready) begin
        e = pend;
        e.acc = cyc;
        e.lat = chk_lat;
        q.push_back(e);
        accepted = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    if (tog) out_ready = ~out_ready;
  endtask

  task automatic send(input logic [7:0] code, input logic [3:0] d, input logic sgl,
                      input logic dbl, input logic [2:0] syn);
    pend = '{d: d, sgl: sgl, dbl: dbl, syn: syn, acc: 0, lat: 1'b0};
    in_valid = 1'b1;
    in_code  = code;
    accepted = 1'b0;
    for (int k = 0; k < 40 && !accepted; k++) tick();
    if (!accepted) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && q.size() != 0; k++) tick();
    check("drain", q.size(), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_code   = 8'h00;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_data", out_data, 0);
    check("rst_syndrome", out_syndrome, 0);
    check("rst_flags", {out_err_single, out_err_double}, 0);
    check("rst_counters", {corr_cnt, uncorr_cnt}, 0);
    rst_n = 1'b1;
    tick();

    chk_lat = 1'b1;
    send(8'h16, 4'h0, 1'b0, 1'b0, 3'd0);
    drain();
    check("clean_corr", corr_cnt, 0);
    send(8'h36, 4'h0, 1'b1, 1'b0, 3'd5);
    drain();
    check("single_corr_cnt", corr_cnt, 1);
    send(8'h17, 4'h0, 1'b1, 1'b0, 3'd0);
    send(8'h10, 4'h0, 1'b0, 1'b1, 3'd3);
    drain();
    check("double_uncorr_cnt", uncorr_cnt, 1);
    send(enc(4'hA) ^ 8'h06, 4'hA, 1'b0, 1'b1, 3'd3);
    send(enc(4'h5) ^ 8'h08, 4'h5, 1'b1, 1'b0, 3'd3);
    send(enc(4'hC) ^ 8'h80, 4'hC, 1'b1, 1'b0, 3'd7);
    drain();
    chk_lat = 1'b0;

    tog = 1'b1;
    for (int d = 0; d < 16; d++) send(enc(4'(d)), 4'(d), 1'b0, 1'b0, 3'd0);
    drain();
    tog = 1'b0;
    out_ready = 1'b1;
    check("stream_stalled", saw_stall, 1);

    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    for (int n = 0; n < 5; n++) send(8'h36, 4'h0, 1'b1, 1'b0, 3'd5);
    drain();
    check("sat_corr_at_3", u2_corr_cnt, 3);
    check("corr_cnt_5", corr_cnt, 5);

    out_ready = 1'b0;
    send(8'h36, 4'h0, 1'b1, 1'b0, 3'd5);
    for (int k = 0; k < 10 && !out_valid; k++) tick();
    check("clr_wait_out_valid", out_valid, 1);
    out_ready = 1'b1;
    cnt_clr   = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_priority", corr_cnt, 0);
    check("clr_priority_sat", u2_corr_cnt, 0);

    out_ready = 1'b0;
    send(enc(4'h3), 4'h3, 1'b0, 1'b0, 3'd0);
    send(enc(4'h9), 4'h9, 1'b0, 1'b0, 3'd0);
    check("inflight_out_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_now_out_valid", out_valid, 0);
    check("rst_now_in_ready", in_ready, 0);
    check("rst_now_out_data", out_data, 0);
    repeat (2) tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("post_reset_quiet", out_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
